// File: rtl/mor1kx_pcu_event_gen_if.sv
// Signal bundle between the core status sources and the PCU event generator.
// master: core side, drives the raw status levels/strobes and observes events.
// slave : event generator, samples the status and drives the pcu_event_* strobes.
interface mor1kx_pcu_event_gen_if;
  logic du_stall_i;
  logic fetch_valid_i;
  logic fetch_flush_i;
  logic lsu_req_i;
  logic lsu_ack_i;
  logic lsu_we_i;
  logic icache_refill_i;
  logic dcache_refill_i;
  logic itlb_reload_i;
  logic dtlb_reload_i;
  logic fetch_stall_i;
  logic lsu_stall_i;
  logic datadep_stall_i;
  logic branch_mispredict_i;

  logic pcu_event_load_o;
  logic pcu_event_store_o;
  logic pcu_event_ifetch_o;
  logic pcu_event_dcache_miss_o;
  logic pcu_event_icache_miss_o;
  logic pcu_event_ifetch_stall_o;
  logic pcu_event_lsu_stall_o;
  logic pcu_event_brn_stall_o;
  logic pcu_event_dtlb_miss_o;
  logic pcu_event_itlb_miss_o;
  logic pcu_event_datadep_stall_o;

  modport master (
    output du_stall_i, fetch_valid_i, fetch_flush_i,
    output lsu_req_i, lsu_ack_i, lsu_we_i,
    output icache_refill_i, dcache_refill_i, itlb_reload_i, dtlb_reload_i,
    output fetch_stall_i, lsu_stall_i, datadep_stall_i, branch_mispredict_i,
    input  pcu_event_load_o, pcu_event_store_o, pcu_event_ifetch_o,
    input  pcu_event_dcache_miss_o, pcu_event_icache_miss_o,
    input  pcu_event_ifetch_stall_o, pcu_event_lsu_stall_o, pcu_event_brn_stall_o,
    input  pcu_event_dtlb_miss_o, pcu_event_itlb_miss_o, pcu_event_datadep_stall_o
  );

  modport slave (
    input  du_stall_i, fetch_valid_i, fetch_flush_i,
    input  lsu_req_i, lsu_ack_i, lsu_we_i,
    input  icache_refill_i, dcache_refill_i, itlb_reload_i, dtlb_reload_i,
    input  fetch_stall_i, lsu_stall_i, datadep_stall_i, branch_mispredict_i,
    output pcu_event_load_o, pcu_event_store_o, pcu_event_ifetch_o,
    output pcu_event_dcache_miss_o, pcu_event_icache_miss_o,
    output pcu_event_ifetch_stall_o, pcu_event_lsu_stall_o, pcu_event_brn_stall_o,
    output pcu_event_dtlb_miss_o, pcu_event_itlb_miss_o, pcu_event_datadep_stall_o
  );
endinterface

// File: rtl/mor1kx_pcu_event_gen.sv
// PCU event generator: turns raw fetch/LSU/cache/MMU/stall status into
// registered single-cycle event strobes for the performance counter unit.
//
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   pcu    slave side of mor1kx_pcu_event_gen_if (status in, pcu_event_* out)
//
// Branch-penalty FSM:
//   state   | meaning
//   IDLE    | no mispredict penalty being attributed
//   PENALTY | counting branch-stall cycles after a mispredict (pen_cnt)
module mor1kx_pcu_event_gen #(
  parameter string FEATURE_DATACACHE        = "ENABLED",
  parameter string FEATURE_INSTRUCTIONCACHE = "ENABLED",
  parameter string FEATURE_DMMU             = "ENABLED",
  parameter string FEATURE_IMMU             = "ENABLED",
  parameter int    BRN_PENALTY_MAX          = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  mor1kx_pcu_event_gen_if.slave    pcu
);

  localparam int CW = $clog2(BRN_PENALTY_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BRN_PENALTY_MAX - 1);

  // Edge-event lanes: 0 dcache, 1 icache, 2 dtlb, 3 itlb
  localparam logic [3:0] EDGE_EN = {
    (FEATURE_IMMU             != "NONE"),
    (FEATURE_DMMU             != "NONE"),
    (FEATURE_INSTRUCTIONCACHE != "NONE"),
    (FEATURE_DATACACHE        != "NONE")
  };

  typedef enum logic {IDLE, PENALTY} brn_state_t;

  brn_state_t    state_q, state_n;
  logic [CW-1:0] pen_cnt_q, pen_cnt_n;

  logic       fetch_ok;
  logic [3:0] edge_lvl;
  logic [3:0] edge_evt;

  logic load_q, store_q, ifetch_q;
  logic ifetch_stall_q, lsu_stall_q, datadep_stall_q, brn_stall_q;

  assign fetch_ok = pcu.fetch_valid_i & ~pcu.fetch_flush_i;
  assign edge_lvl = {pcu.itlb_reload_i, pcu.dtlb_reload_i,
                     pcu.icache_refill_i, pcu.dcache_refill_i};

  // ---------------------------------------------------------------------
  // Branch-penalty FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pen_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      pen_cnt_q <= pen_cnt_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    pen_cnt_n = pen_cnt_q;
    case (state_q)
      IDLE: begin
        if (pcu.branch_mispredict_i) begin
          state_n   = PENALTY;
          pen_cnt_n = '0;
        end
      end
      PENALTY: begin
        // A fresh mispredict takes priority over a delivered fetch.
        if (pcu.branch_mispredict_i) begin
          pen_cnt_n = '0;
        end else if (fetch_ok || (pen_cnt_q == CNT_LAST)) begin
          state_n   = IDLE;
          pen_cnt_n = '0;
        end else begin
          pen_cnt_n = pen_cnt_q + CW'(1);
        end
      end
      default: begin
        state_n   = IDLE;
        pen_cnt_n = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Transaction, level and branch-stall strobes
  // brn_stall mirrors the registered state so the strobe is high exactly
  // for the cycles spent in PENALTY, and drops with the async reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q          <= 1'b0;
      store_q         <= 1'b0;
      ifetch_q        <= 1'b0;
      ifetch_stall_q  <= 1'b0;
      lsu_stall_q     <= 1'b0;
      datadep_stall_q <= 1'b0;
      brn_stall_q     <= 1'b0;
    end else begin
      load_q          <= pcu.lsu_req_i & pcu.lsu_ack_i & ~pcu.lsu_we_i & ~pcu.du_stall_i;
      store_q         <= pcu.lsu_req_i & pcu.lsu_ack_i &  pcu.lsu_we_i & ~pcu.du_stall_i;
      ifetch_q        <= fetch_ok & ~pcu.du_stall_i;
      ifetch_stall_q  <= pcu.fetch_stall_i   & ~pcu.du_stall_i;
      lsu_stall_q     <= pcu.lsu_stall_i     & ~pcu.du_stall_i;
      datadep_stall_q <= pcu.datadep_stall_i & ~pcu.du_stall_i;
      brn_stall_q     <= (state_n == PENALTY) & ~pcu.du_stall_i;
    end
  end

  // ---------------------------------------------------------------------
  // Miss events: one strobe per rising edge of a refill/reload level.
  // History keeps tracking during debug stall, so masked edges are lost.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_edge
    if (EDGE_EN[i]) begin : g_on
      logic prev_q;
      logic evt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= 1'b0;
          evt_q  <= 1'b0;
        end else begin
          prev_q <= edge_lvl[i];
          evt_q  <= edge_lvl[i] & ~prev_q & ~pcu.du_stall_i;
        end
      end
      assign edge_evt[i] = evt_q;
    end else begin : g_off
      assign edge_evt[i] = 1'b0;
    end
  end

  assign pcu.pcu_event_load_o          = load_q;
  assign pcu.pcu_event_store_o         = store_q;
  assign pcu.pcu_event_ifetch_o        = ifetch_q;
  assign pcu.pcu_event_dcache_miss_o   = edge_evt[0];
  assign pcu.pcu_event_icache_miss_o   = edge_evt[1];
  assign pcu.pcu_event_dtlb_miss_o     = edge_evt[2];
  assign pcu.pcu_event_itlb_miss_o     = edge_evt[3];
  assign pcu.pcu_event_ifetch_stall_o  = ifetch_stall_q;
  assign pcu.pcu_event_lsu_stall_o     = lsu_stall_q;
  assign pcu.pcu_event_datadep_stall_o = datadep_stall_q;
  assign pcu.pcu_event_brn_stall_o     = brn_stall_q;

endmodule

// File: tb/tb_mor1kx_pcu_event_gen.sv
// Directed scoreboard bench for mor1kx_pcu_event_gen (BRN_PENALTY_MAX = 16).
// Each stimulus cycle pushes the hand-computed event vector expected right
// after that cycle's rising edge; a monitor pops and compares it.
module tb_mor1kx_pcu_event_gen;

  logic clk;
  logic rst_n;
  logic rst_drv;

  mor1kx_pcu_event_gen_if pif ();

  mor1kx_pcu_event_gen #(
    .FEATURE_DATACACHE        ("ENABLED"),
    .FEATURE_INSTRUCTIONCACHE ("ENABLED"),
    .FEATURE_DMMU             ("ENABLED"),
    .FEATURE_IMMU             ("ENABLED"),
    .BRN_PENALTY_MAX          (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pcu   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input vector bits
  localparam logic [13:0] I_MIS = 14'h0001;
  localparam logic [13:0] I_DD  = 14'h0002;
  localparam logic [13:0] I_LSS = 14'h0004;
  localparam logic [13:0] I_FS  = 14'h0008;
  localparam logic [13:0] I_DTR = 14'h0010;
  localparam logic [13:0] I_ITR = 14'h0020;
  localparam logic [13:0] I_DCR = 14'h0040;
  localparam logic [13:0] I_ICR = 14'h0080;
  localparam logic [13:0] I_WE  = 14'h0100;
  localparam logic [13:0] I_ACK = 14'h0200;
  localparam logic [13:0] I_REQ = 14'h0400;
  localparam logic [13:0] I_FL  = 14'h0800;
  localparam logic [13:0] I_FV  = 14'h1000;
  localparam logic [13:0] I_DU  = 14'h2000;

  // Event vector bits
  localparam logic [10:0] E_NONE   = 11'h000;
  localparam logic [10:0] E_LOAD   = 11'h001;
  localparam logic [10:0] E_STORE  = 11'h002;
  localparam logic [10:0] E_IFETCH = 11'h004;
  localparam logic [10:0] E_DCM    = 11'h008;
  localparam logic [10:0] E_ICM    = 11'h010;
  localparam logic [10:0] E_IFS    = 11'h020;
  localparam logic [10:0] E_LSS    = 11'h040;
  localparam logic [10:0] E_BRN    = 11'h080;
  localparam logic [10:0] E_DTLB   = 11'h100;
  localparam logic [10:0] E_ITLB   = 11'h200;
  localparam logic [10:0] E_DD     = 11'h400;

  logic [10:0] act;
  assign act = {pif.pcu_event_datadep_stall_o, pif.pcu_event_itlb_miss_o,
                pif.pcu_event_dtlb_miss_o, pif.pcu_event_brn_stall_o,
                pif.pcu_event_lsu_stall_o, pif.pcu_event_ifetch_stall_o,
                pif.pcu_event_icache_miss_o, pif.pcu_event_dcache_miss_o,
                pif.pcu_event_ifetch_o, pif.pcu_event_store_o,
                pif.pcu_event_load_o};

  logic [10:0] exp_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic drive(input logic [13:0] iv);
    {pif.du_stall_i, pif.fetch_valid_i, pif.fetch_flush_i,
     pif.lsu_req_i, pif.lsu_ack_i, pif.lsu_we_i,
     pif.icache_refill_i, pif.dcache_refill_i,
     pif.itlb_reload_i, pif.dtlb_reload_i,
     pif.fetch_stall_i, pif.lsu_stall_i, pif.datadep_stall_i,
     pif.branch_mispredict_i} = iv;
  endtask

  // One input cycle; ev is the event vector expected after its rising edge.
  task automatic cyc(input logic [13:0] iv, input logic [10:0] ev, input string tag);
    @(negedge clk);
    rst_n = rst_drv;
    drive(iv);
    exp_q.push_back(ev);
    tag_q.push_back(tag);
  endtask

  // Monitor
  initial begin
    logic [10:0] e;
    string       t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_vec++;
        if (act !== e) begin
          n_err++;
          $display("FAIL %s: events got %b expected %b at %0t", t, act, e, $time);
        end
      end
    end
  end

  initial begin
    rst_drv = 1'b0;
    rst_n   = 1'b0;
    drive(14'h3FFF);

    // 1. Reset with all inputs high, then release with icache refill held.
    for (int i = 0; i < 3; i++) cyc(14'h3FFF, E_NONE, "reset_all_high");
    rst_drv = 1'b1;
    cyc(I_ICR, E_ICM, "rst_release_icm");
    for (int i = 0; i < 9; i++) cyc(I_ICR, E_NONE, "icr_hold");
    cyc(14'h0, E_NONE, "icr_drop");

    // 2. LSU transactions.
    cyc(I_REQ, E_NONE, "load_req1");
    cyc(I_REQ, E_NONE, "load_req2");
    cyc(I_REQ | I_ACK, E_LOAD, "load_ack");
    cyc(I_REQ, E_NONE, "load_req4");
    cyc(I_REQ | I_WE, E_NONE, "store_req1");
    cyc(I_REQ | I_WE, E_NONE, "store_req2");
    cyc(I_REQ | I_WE | I_ACK, E_STORE, "store_ack");
    cyc(I_REQ | I_WE, E_NONE, "store_req4");
    cyc(I_ACK | I_WE, E_NONE, "ack_no_req");

    // 3. Edge vs level: dcache refill 5 high, 1 low, 3 high with lsu_stall.
    cyc(I_DCR | I_LSS, E_DCM | E_LSS, "dcm_edge1");
    for (int i = 0; i < 4; i++) cyc(I_DCR | I_LSS, E_LSS, "dcm_hold1");
    cyc(14'h0, E_NONE, "dcm_gap");
    cyc(I_DCR | I_LSS, E_DCM | E_LSS, "dcm_edge2");
    for (int i = 0; i < 2; i++) cyc(I_DCR | I_LSS, E_LSS, "dcm_hold2");
    cyc(14'h0, E_NONE, "dcm_end");

    // Simultaneous independent events.
    cyc(I_DTR | I_FS | I_REQ | I_ACK | I_FV, E_DTLB | E_IFS | E_LOAD | E_IFETCH, "combo");
    cyc(I_DTR, E_NONE, "dtlb_hold");
    cyc(14'h0, E_NONE, "combo_end");

    // 4a. Mispredict, fetch 4 cycles later -> 4 penalty cycles.
    cyc(I_MIS, E_BRN, "brn_fetch_mis");
    for (int i = 0; i < 3; i++) cyc(14'h0, E_BRN, "brn_fetch_pen");
    cyc(I_FV, E_IFETCH, "brn_fetch_exit");
    cyc(14'h0, E_NONE, "brn_fetch_idle");

    // 4b. No fetch -> exactly 16 penalty cycles.
    cyc(I_MIS, E_BRN, "brn_max_mis");
    for (int i = 0; i < 15; i++) cyc(14'h0, E_BRN, "brn_max_pen");
    cyc(14'h0, E_NONE, "brn_max_exit");
    cyc(14'h0, E_NONE, "brn_max_idle");

    // 4c. Second mispredict in penalty cycle 10 -> 26 cycles total.
    cyc(I_MIS, E_BRN, "brn_re_mis1");
    for (int i = 0; i < 9; i++) cyc(14'h0, E_BRN, "brn_re_pen1");
    cyc(I_MIS, E_BRN, "brn_re_mis2");
    for (int i = 0; i < 15; i++) cyc(14'h0, E_BRN, "brn_re_pen2");
    cyc(14'h0, E_NONE, "brn_re_exit");

    // 4d. Mispredict and valid fetch together: mispredict wins.
    cyc(I_MIS | I_FV, E_BRN | E_IFETCH, "brn_mis_fetch_same");
    cyc(I_FV, E_IFETCH, "brn_mis_fetch_exit");
    cyc(14'h0, E_NONE, "brn_mis_fetch_idle");

    // 5. Debug mask.
    cyc(I_DU | I_FV | I_ITR | I_DD, E_NONE, "du_mask1");
    cyc(I_DU | I_FV | I_ITR | I_DD, E_NONE, "du_mask2");
    cyc(I_FV | I_ITR | I_DD, E_IFETCH | E_DD, "du_release");
    cyc(14'h0, E_NONE, "du_idle");

    // 6. Flush qualification, also during PENALTY.
    cyc(I_FV | I_FL, E_NONE, "flush_idle");
    cyc(I_MIS, E_BRN, "flush_mis");
    cyc(I_FV | I_FL, E_BRN, "flush_in_pen");
    cyc(I_FV, E_IFETCH, "flush_pen_exit");
    cyc(14'h0, E_NONE, "flush_idle2");

    // Async reset during PENALTY clears brn_stall without a clock edge.
    cyc(I_MIS, E_BRN, "arst_mis");
    cyc(14'h0, E_BRN, "arst_pen");
    rst_drv = 1'b0;
    cyc(14'h0, E_NONE, "arst_hold");
    #1;
    n_vec++;
    if (act !== E_NONE) begin
      n_err++;
      $display("FAIL arst_immediate: events got %b expected %b", act, E_NONE);
    end
    rst_drv = 1'b1;
    cyc(14'h0, E_NONE, "arst_release");
    cyc(I_FV, E_IFETCH, "arst_after");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mor1kx_pcu_event_gen.md
# mor1kx_pcu_event_gen

Event-shaping stage directly upstream of the performance counter unit. Converts raw fetch, LSU, cache, MMU and pipeline-control status signals into registered, single-cycle, one-per-occurrence event strobes on the `pcu_event_*` inputs of the PCU. Cache and TLB misses are counted once per refill or reload. Stall events are counted once per stalled cycle. All events are suppressed while the debug unit holds the core stalled.

## Interface

**Parameters**
- `FEATURE_DATACACHE`, default "ENABLED": when "NONE", `pcu_event_dcache_miss_o` is tied to 0.
- `FEATURE_INSTRUCTIONCACHE`, default "ENABLED": when "NONE", `pcu_event_icache_miss_o` is tied to 0.
- `FEATURE_DMMU`, default "ENABLED": when "NONE", `pcu_event_dtlb_miss_o` is tied to 0.
- `FEATURE_IMMU`, default "ENABLED": when "NONE", `pcu_event_itlb_miss_o` is tied to 0.
- `BRN_PENALTY_MAX`, default 16: maximum number of branch-stall cycles attributed to one mispredict. Legal range is 1–255.

**Ports**

Clock and reset:
- `clk`  in  1  core clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.

Control:
- `du_stall_i`  in  1  debug stall; masks all event outputs.

Fetch:
- `fetch_valid_i`  in  1  fetch stage delivers an instruction this cycle.
- `fetch_flush_i`  in  1  pipeline flush; the fetch delivered in this cycle is discarded.

LSU:
- `lsu_req_i`  in  1  LSU bus request.
- `lsu_ack_i`  in  1  LSU bus acknowledge.
- `lsu_we_i`  in  1  write flag, qualified by `lsu_req_i`.

Cache and MMU status (levels):
- `icache_refill_i`  in  1  instruction cache refill in progress.
- `dcache_refill_i`  in  1  data cache refill in progress.
- `itlb_reload_i`  in  1  instruction TLB reload busy.
- `dtlb_reload_i`  in  1  data TLB reload busy.

Stall sources (levels):
- `fetch_stall_i`  in  1  fetch-stage stall.
- `lsu_stall_i`  in  1  LSU stall.
- `datadep_stall_i`  in  1  operand-dependency stall.
- `branch_mispredict_i`  in  1  single-cycle mispredict / redirect strobe.

Event outputs (each 1 bit, registered, single-cycle strobe):
- `pcu_event_load_o`  out  1  one completed load.
- `pcu_event_store_o`  out  1  one completed store.
- `pcu_event_ifetch_o`  out  1  one delivered instruction fetch.
- `pcu_event_dcache_miss_o`  out  1  one data cache miss.
- `pcu_event_icache_miss_o`  out  1  one instruction cache miss.
- `pcu_event_ifetch_stall_o`  out  1  one fetch-stall cycle.
- `pcu_event_lsu_stall_o`  out  1  one LSU-stall cycle.
- `pcu_event_brn_stall_o`  out  1  one branch-penalty cycle.
- `pcu_event_dtlb_miss_o`  out  1  one data TLB miss.
- `pcu_event_itlb_miss_o`  out  1  one instruction TLB miss.
- `pcu_event_datadep_stall_o`  out  1  one dependency-stall cycle.

## Operation

Each rule below gives the condition sampled in cycle N. When the condition holds, the corresponding output is 1 in cycle N+1.

**Transaction events**
- Load: `lsu_req_i & lsu_ack_i & ~lsu_we_i`.
- Store: `lsu_req_i & lsu_ack_i & lsu_we_i`.
- Ifetch: `fetch_valid_i & ~fetch_flush_i`.

**Edge events (cache and TLB misses)**
- Each level input has a history register `prev_x`.
- The miss event fires when `x & ~prev_x` (rising edge).
- A refill or reload held high for many cycles produces exactly one strobe.
- Back-to-back refills separated by at least one low cycle produce two strobes.

**Level events (per-cycle stalls)**
- ifetch_stall fires on `fetch_stall_i`.
- lsu_stall fires on `lsu_stall_i`.
- datadep_stall fires on `datadep_stall_i`.
- Each fires once for every cycle its input is high.

**Branch-penalty FSM (states IDLE, PENALTY; counter `pen_cnt` is clog2(BRN_PENALTY_MAX+1) bits)**
- IDLE → PENALTY on `branch_mispredict_i`; `pen_cnt` is loaded with 0.
- In PENALTY:
  - `pcu_event_brn_stall_o` is asserted for each cycle spent in PENALTY.
  - `pen_cnt` increments each cycle.
  - PENALTY → IDLE on `fetch_valid_i & ~fetch_flush_i`, or when `pen_cnt == BRN_PENALTY_MAX-1`, whichever occurs first.
- A mispredict while in PENALTY reloads `pen_cnt` to 0 and stays in PENALTY.
- A mispredict and a valid fetch in the same cycle: the mispredict wins, and the state is PENALTY next cycle.
- The brn_stall output is registered from the current state: the cycle after the mispredict strobe is the first penalty cycle.

**Debug masking**
- While `du_stall_i` is high, all outputs are 0 in the following cycle.
- History registers and the FSM keep updating while masked, so an edge that occurs during a debug stall is lost rather than deferred.

**Simultaneous events**
- All outputs are independent; any combination may be high in the same cycle.

**Disabled features**
- When a feature parameter is "NONE", the output is constant 0 and its history register is removed.

## Timing

- Reset (`rst_n` low, asynchronous):
  - every output is 0;
  - all `prev_*` registers are 0;
  - FSM is IDLE and `pen_cnt` is 0.
- Because history resets to 0, a refill level that is already high in the first cycle after reset release produces one miss strobe.
- Reset asserted during PENALTY: immediate return to IDLE and brn_stall goes to 0 in the same cycle (asynchronous reset).
- Latency is exactly 1 cycle from the qualifying input to the strobe, for every event. There is no combinational path from any input to any output.
- No output is ever asserted for more than 1 cycle per occurrence, except the level events and brn_stall, which assert for consecutive cycles.

## Test plan

1. **Reset value.** Hold `rst_n`=0 with all inputs at 1 → all outputs 0. Release reset with `icache_refill_i` held at 1 for 10 cycles → exactly one `pcu_event_icache_miss_o` pulse, one cycle after release.
2. **LSU transactions.** Issue `lsu_req_i`=1 for 4 cycles with `lsu_ack_i` high only in cycle 3, `lsu_we_i`=0 → one load strobe in cycle 4 and no store strobe. Repeat with `lsu_we_i`=1 → one store strobe, no load strobe.
3. **Edge vs level.** Drive `dcache_refill_i` high for 5 cycles, low for 1, high for 3, while `lsu_stall_i` tracks it → dcache_miss gives 2 strobes total; lsu_stall gives 8 strobe cycles.
4. **Branch penalty.** Pulse mispredict, then `fetch_valid_i` 4 cycles later → brn_stall high for 4 cycles. With BRN_PENALTY_MAX=16 and no fetch → exactly 16 cycles. A second mispredict at penalty cycle 10 → 10+16=26 cycles total.
5. **Debug mask.** Drive `du_stall_i`=1 while `fetch_valid_i`=1, `itlb_reload_i` rises, and `datadep_stall_i`=1 → all outputs 0. After `du_stall_i` drops with `itlb_reload_i` still high → no itlb_miss strobe, while ifetch and datadep strobes resume one cycle later.
6. **Flush qualification.** `fetch_valid_i`=1 and `fetch_flush_i`=1 in the same cycle → no ifetch strobe. During PENALTY this fetch also does not exit the FSM.
